// File: rtl/eth_port_mux.sv
// Purpose: RX round-robin packet merge of NUM_PORTS MAC streams; TX tdest-routed demux with drop counting.
// Latency: RX 1-cycle arbitration then combinational pass-through (1 bubble per packet); TX zero added latency.
// Backpressure: RX ready forwarded only to the granted port; TX ready taken from routed port, forced high on drop.
module eth_port_mux #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 64,
    parameter int DEST_WIDTH = 1,
    localparam int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                             clock,
    input  logic                             resetn,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_rx_tdata,
    input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_rx_tkeep,
    input  logic [NUM_PORTS-1:0]             s_rx_tlast,
    input  logic [NUM_PORTS-1:0]             s_rx_tuser,
    input  logic [NUM_PORTS-1:0]             s_rx_tvalid,
    output logic [NUM_PORTS-1:0]             s_rx_tready,
    output logic [DATA_WIDTH-1:0]            m_rx_tdata,
    output logic [KEEP_WIDTH-1:0]            m_rx_tkeep,
    output logic                             m_rx_tlast,
    output logic                             m_rx_tuser,
    output logic                             m_rx_tvalid,
    output logic [DEST_WIDTH-1:0]            m_rx_tdest,
    input  logic                             m_rx_tready,
    input  logic [DATA_WIDTH-1:0]            s_tx_tdata,
    input  logic [KEEP_WIDTH-1:0]            s_tx_tkeep,
    input  logic                             s_tx_tlast,
    input  logic                             s_tx_tuser,
    input  logic                             s_tx_tvalid,
    input  logic [DEST_WIDTH-1:0]            s_tx_tdest,
    output logic                             s_tx_tready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]  m_tx_tdata,
    output logic [NUM_PORTS*KEEP_WIDTH-1:0]  m_tx_tkeep,
    output logic [NUM_PORTS-1:0]             m_tx_tlast,
    output logic [NUM_PORTS-1:0]             m_tx_tuser,
    output logic [NUM_PORTS-1:0]             m_tx_tvalid,
    input  logic [NUM_PORTS-1:0]             m_tx_tready,
    output logic [15:0]                      tx_drop_count
);

    localparam int DW1 = DEST_WIDTH + 1;

    if ((2 ** DEST_WIDTH) < NUM_PORTS) begin : g_bad_dest_width
        $error("eth_port_mux: DEST_WIDTH too small for NUM_PORTS");
    end
    if (NUM_PORTS < 1 || NUM_PORTS > 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_params
        $error("eth_port_mux: NUM_PORTS must be 1..8 and DATA_WIDTH a multiple of 8");
    end

    typedef enum logic {RX_IDLE, RX_GRANT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_ROUTE, TX_DROP} tx_state_t;

    rx_state_t             r_rx_state, w_rx_next;
    logic [DEST_WIDTH-1:0] r_rx_sel, r_rr_last, w_grant;
    logic                  w_any_vld, w_rx_done;

    tx_state_t             r_tx_state, w_tx_next;
    logic [DEST_WIDTH-1:0] r_tx_dest, w_tx_dest;
    logic                  w_dest_ok, w_dest_rdy, w_tx_route, w_tx_rdy, w_drop_inc;
    logic [15:0]           r_drop_cnt;

    // Round-robin search starts one past the last port that completed a packet.
    always_comb begin
        w_grant   = '0;
        w_any_vld = 1'b0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            for (int j = 0; j < NUM_PORTS; j++) begin
                if (j == (int'(r_rr_last) + i) % NUM_PORTS && s_rx_tvalid[j] && !w_any_vld) begin
                    w_any_vld = 1'b1;
                    w_grant   = DEST_WIDTH'(j);
                end
            end
        end
    end

    always_comb begin
        m_rx_tdata  = '0;
        m_rx_tkeep  = '0;
        m_rx_tlast  = 1'b0;
        m_rx_tuser  = 1'b0;
        m_rx_tvalid = 1'b0;
        m_rx_tdest  = '0;
        s_rx_tready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (r_rx_sel == DEST_WIDTH'(i)) begin
                m_rx_tdata  = s_rx_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_rx_tkeep  = s_rx_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                m_rx_tlast  = s_rx_tlast[i];
                m_rx_tuser  = s_rx_tuser[i];
                if (r_rx_state == RX_GRANT) begin
                    m_rx_tvalid    = s_rx_tvalid[i];
                    s_rx_tready[i] = m_rx_tready;
                end
            end
        end
        if (r_rx_state == RX_GRANT) begin
            m_rx_tdest = r_rx_sel;
        end
    end

    assign w_rx_done = m_rx_tvalid && m_rx_tready && m_rx_tlast;

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_any_vld) w_rx_next = RX_GRANT;
            RX_GRANT: if (w_rx_done) w_rx_next = RX_IDLE;
            default:  w_rx_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_rx_state <= RX_IDLE;
            r_rx_sel   <= '0;
            r_rr_last  <= DEST_WIDTH'(NUM_PORTS - 1);
        end else begin
            r_rx_state <= w_rx_next;
            if (r_rx_state == RX_IDLE && w_any_vld) r_rx_sel <= w_grant;
            if (w_rx_done) r_rr_last <= r_rx_sel;
        end
    end

    // Destination is decoded live only in IDLE; mid-packet beats follow the latched port.
    assign w_dest_ok = {1'b0, s_tx_tdest} < DW1'(NUM_PORTS);
    assign w_tx_dest = (r_tx_state == TX_IDLE) ? s_tx_tdest : r_tx_dest;

    always_comb begin
        w_dest_rdy = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (w_tx_dest == DEST_WIDTH'(i)) w_dest_rdy = m_tx_tready[i];
        end
    end

    always_comb begin
        w_tx_next  = r_tx_state;
        w_tx_route = 1'b0;
        w_tx_rdy   = 1'b0;
        w_drop_inc = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (s_tx_tvalid && w_dest_ok) begin
                    w_tx_route = 1'b1;
                    w_tx_rdy   = w_dest_rdy;
                    if (w_dest_rdy && !s_tx_tlast) w_tx_next = TX_ROUTE;
                end else if (s_tx_tvalid) begin
                    w_tx_rdy   = 1'b1;
                    w_drop_inc = 1'b1;
                    if (!s_tx_tlast) w_tx_next = TX_DROP;
                end
            end
            TX_ROUTE: begin
                w_tx_route = 1'b1;
                w_tx_rdy   = w_dest_rdy;
                if (s_tx_tvalid && w_dest_rdy && s_tx_tlast) w_tx_next = TX_IDLE;
            end
            TX_DROP: begin
                w_tx_rdy = 1'b1;
                if (s_tx_tvalid && s_tx_tlast) w_tx_next = TX_IDLE;
            end
            default: w_tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        m_tx_tvalid = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            m_tx_tvalid[i] = resetn && w_tx_route && s_tx_tvalid && (w_tx_dest == DEST_WIDTH'(i));
        end
    end

    assign s_tx_tready   = resetn && w_tx_rdy;
    assign m_tx_tdata    = {NUM_PORTS{s_tx_tdata}};
    assign m_tx_tkeep    = {NUM_PORTS{s_tx_tkeep}};
    assign m_tx_tlast    = {NUM_PORTS{s_tx_tlast}};
    assign m_tx_tuser    = {NUM_PORTS{s_tx_tuser}};
    assign tx_drop_count = r_drop_cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_tx_state <= TX_IDLE;
            r_tx_dest  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            if (r_tx_state == TX_IDLE && w_tx_next == TX_ROUTE) r_tx_dest <= s_tx_tdest;
            if (w_drop_inc && r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_eth_port_mux.sv
// Directed bench for eth_port_mux with three ports so that tdest=3 exercises the drop path.
module tb_eth_port_mux;

    localparam int NP = 3;
    localparam int DW = 64;
    localparam int KW = 8;
    localparam int DST = 2;

    logic              clock;
    logic              resetn;
    logic [NP*DW-1:0]  s_rx_tdata;
    logic [NP*KW-1:0]  s_rx_tkeep;
    logic [NP-1:0]     s_rx_tlast, s_rx_tuser, s_rx_tvalid, s_rx_tready;
    logic [DW-1:0]     m_rx_tdata;
    logic [KW-1:0]     m_rx_tkeep;
    logic              m_rx_tlast, m_rx_tuser, m_rx_tvalid, m_rx_tready;
    logic [DST-1:0]    m_rx_tdest;
    logic [DW-1:0]     s_tx_tdata;
    logic [KW-1:0]     s_tx_tkeep;
    logic              s_tx_tlast, s_tx_tuser, s_tx_tvalid, s_tx_tready;
    logic [DST-1:0]    s_tx_tdest;
    logic [NP*DW-1:0]  m_tx_tdata;
    logic [NP*KW-1:0]  m_tx_tkeep;
    logic [NP-1:0]     m_tx_tlast, m_tx_tuser, m_tx_tvalid, m_tx_tready;
    logic [15:0]       tx_drop_count;

    int n_checks = 0;
    int n_fail   = 0;

    eth_port_mux #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .DEST_WIDTH(DST)) dut (
        .clock(clock), .resetn(resetn),
        .s_rx_tdata(s_rx_tdata), .s_rx_tkeep(s_rx_tkeep), .s_rx_tlast(s_rx_tlast),
        .s_rx_tuser(s_rx_tuser), .s_rx_tvalid(s_rx_tvalid), .s_rx_tready(s_rx_tready),
        .m_rx_tdata(m_rx_tdata), .m_rx_tkeep(m_rx_tkeep), .m_rx_tlast(m_rx_tlast),
        .m_rx_tuser(m_rx_tuser), .m_rx_tvalid(m_rx_tvalid), .m_rx_tdest(m_rx_tdest),
        .m_rx_tready(m_rx_tready),
        .s_tx_tdata(s_tx_tdata), .s_tx_tkeep(s_tx_tkeep), .s_tx_tlast(s_tx_tlast),
        .s_tx_tuser(s_tx_tuser), .s_tx_tvalid(s_tx_tvalid), .s_tx_tdest(s_tx_tdest),
        .s_tx_tready(s_tx_tready),
        .m_tx_tdata(m_tx_tdata), .m_tx_tkeep(m_tx_tkeep), .m_tx_tlast(m_tx_tlast),
        .m_tx_tuser(m_tx_tuser), .m_tx_tvalid(m_tx_tvalid), .m_tx_tready(m_tx_tready),
        .tx_drop_count(tx_drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rx(input int p, input logic v, input logic [DW-1:0] d, input logic l, input logic u);
        s_rx_tvalid[p]        = v;
        s_rx_tdata[p*DW +: DW] = d;
        s_rx_tkeep[p*KW +: KW] = 8'hFF;
        s_rx_tlast[p]         = l;
        s_rx_tuser[p]         = u;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        s_rx_tdata = '0; s_rx_tkeep = '0; s_rx_tlast = '0; s_rx_tuser = '0;
        s_rx_tvalid = '1; m_rx_tready = 1'b1;
        s_tx_tdata = '0; s_tx_tkeep = '1; s_tx_tlast = 1'b0; s_tx_tuser = 1'b0;
        s_tx_tvalid = 1'b1; s_tx_tdest = 2'd1; m_tx_tready = '1;
        step(); step();
        n_checks++;
        if (s_rx_tready !== 3'b000) begin n_fail++; $display("FAIL reset_s_rx_tready: got %b expected 000", s_rx_tready); end
        n_checks++;
        if (m_rx_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_rx_tvalid: got %b expected 0", m_rx_tvalid); end
        n_checks++;
        if (s_tx_tready !== 1'b0) begin n_fail++; $display("FAIL reset_s_tx_tready: got %b expected 0", s_tx_tready); end
        n_checks++;
        if (m_tx_tvalid !== 3'b000) begin n_fail++; $display("FAIL reset_m_tx_tvalid: got %b expected 000", m_tx_tvalid); end
        n_checks++;
        if (tx_drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop_count: got %h expected 0000", tx_drop_count); end
        n_checks++;
        if (m_rx_tdest !== 2'd0) begin n_fail++; $display("FAIL reset_m_rx_tdest: got %0d expected 0", m_rx_tdest); end
        s_rx_tvalid = '0; s_tx_tvalid = 1'b0;
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_rx_fairness();
        int b[2];
        int p[2];
        logic [NP-1:0] rdy;
        logic [DW-1:0] exp_data;
        int pos, src;
        b = '{0, 0};
        p = '{0, 0};
        m_rx_tready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            for (int q = 0; q < 2; q++) begin
                set_rx(q, 1'b1, {16'hA5A5, 16'(q), 16'(p[q]), 16'(b[q])}, b[q] == 3, 1'b0);
            end
            #1;
            pos = k % 5;
            n_checks++;
            if (m_rx_tvalid !== (pos != 0)) begin
                n_fail++; $display("FAIL fair_valid cyc%0d: got %b expected %b", k, m_rx_tvalid, pos != 0);
            end
            if (pos != 0) begin
                src = (k / 5) % 2;
                exp_data = {16'hA5A5, 16'(src), 16'((k / 5) / 2), 16'(pos - 1)};
                n_checks++;
                if ({m_rx_tdest, m_rx_tlast, m_rx_tkeep, m_rx_tdata} !== {2'(src), pos == 4, 8'hFF, exp_data}) begin
                    n_fail++;
                    $display("FAIL fair_beat cyc%0d: got dest=%0d last=%b data=%h expected dest=%0d last=%b data=%h",
                             k, m_rx_tdest, m_rx_tlast, m_rx_tdata, src, pos == 4, exp_data);
                end
            end
            rdy = s_rx_tready;
            step();
            for (int q = 0; q < 2; q++) begin
                if (rdy[q]) begin
                    if (b[q] == 3) begin b[q] = 0; p[q]++; end
                    else b[q]++;
                end
            end
        end
        for (int q = 0; q < NP; q++) set_rx(q, 1'b0, '0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_rx_backpressure();
        bit       t_p0v[8]  = '{0, 1, 1, 1, 1, 1, 1, 1};
        bit       t_p1v[8]  = '{1, 1, 1, 1, 1, 1, 0, 0};
        int       t_p1b[8]  = '{0, 0, 1, 1, 2, 2, 0, 0};
        bit       t_mrdy[8] = '{1, 1, 0, 1, 0, 1, 1, 1};
        bit [2:0] t_erdy[8] = '{3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b010, 3'b000, 3'b001};
        bit       t_emv[8]  = '{0, 1, 1, 1, 1, 1, 0, 1};
        bit [1:0] t_edst[8] = '{0, 1, 1, 1, 1, 1, 0, 0};
        bit       t_elst[8] = '{0, 0, 0, 0, 1, 1, 0, 1};
        bit       t_eusr[8] = '{0, 0, 0, 0, 1, 1, 0, 0};
        logic [DW-1:0] d0, d1, ed;
        d0 = 64'h0000_0000_0000_00AA;
        for (int c = 0; c < 8; c++) begin
            d1 = 64'h1111_0000_0000_0000 | 64'(t_p1b[c]);
            set_rx(0, t_p0v[c], d0, 1'b1, 1'b0);
            set_rx(1, t_p1v[c], d1, t_p1b[c] == 2, t_p1b[c] == 2);
            m_rx_tready = t_mrdy[c];
            #1;
            n_checks++;
            if (s_rx_tready !== t_erdy[c]) begin
                n_fail++; $display("FAIL bp_s_rx_tready cyc%0d: got %b expected %b", c, s_rx_tready, t_erdy[c]);
            end
            n_checks++;
            if (m_rx_tvalid !== t_emv[c]) begin
                n_fail++; $display("FAIL bp_m_rx_tvalid cyc%0d: got %b expected %b", c, m_rx_tvalid, t_emv[c]);
            end
            if (t_emv[c]) begin
                ed = (c == 7) ? d0 : d1;
                n_checks++;
                if ({m_rx_tdest, m_rx_tlast, m_rx_tuser, m_rx_tdata} !== {t_edst[c], t_elst[c], t_eusr[c], ed}) begin
                    n_fail++;
                    $display("FAIL bp_beat cyc%0d: got dest=%0d last=%b user=%b data=%h expected dest=%0d last=%b user=%b data=%h",
                             c, m_rx_tdest, m_rx_tlast, m_rx_tuser, m_rx_tdata, t_edst[c], t_elst[c], t_eusr[c], ed);
                end
            end
            step();
        end
        for (int q = 0; q < NP; q++) set_rx(q, 1'b0, '0, 1'b0, 1'b0);
        step();
    endtask

    task automatic test_tx_routing();
        bit       t_v[8]    = '{1, 1, 1, 1, 1, 1, 1, 0};
        bit [1:0] t_dst[8]  = '{1, 0, 0, 0, 0, 0, 2, 0};
        bit       t_lst[8]  = '{0, 0, 0, 0, 1, 1, 1, 0};
        int       t_beat[8] = '{0, 1, 1, 1, 2, 3, 4, 0};
        bit [2:0] t_mrdy[8] = '{3'b111, 3'b101, 3'b101, 3'b111, 3'b111, 3'b111, 3'b111, 3'b111};
        bit [2:0] t_emv[8]  = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b001, 3'b100, 3'b000};
        bit       t_erdy[8] = '{1, 0, 0, 1, 1, 1, 1, 0};
        int       t_ep[8]   = '{1, 1, 1, 1, 1, 0, 2, 0};
        logic [DW-1:0] d;
        for (int c = 0; c < 8; c++) begin
            d = 64'hC0DE_0000_0000_0000 | 64'(t_beat[c]);
            s_tx_tvalid = t_v[c]; s_tx_tdest = t_dst[c]; s_tx_tlast = t_lst[c];
            s_tx_tdata = d; m_tx_tready = t_mrdy[c];
            #1;
            n_checks++;
            if (m_tx_tvalid !== t_emv[c]) begin
                n_fail++; $display("FAIL route_m_tx_tvalid cyc%0d: got %b expected %b", c, m_tx_tvalid, t_emv[c]);
            end
            n_checks++;
            if (s_tx_tready !== t_erdy[c]) begin
                n_fail++; $display("FAIL route_s_tx_tready cyc%0d: got %b expected %b", c, s_tx_tready, t_erdy[c]);
            end
            if (t_emv[c] != 3'b000) begin
                n_checks++;
                if ({m_tx_tlast[t_ep[c]], m_tx_tdata[t_ep[c]*DW +: DW]} !== {t_lst[c], d}) begin
                    n_fail++;
                    $display("FAIL route_beat cyc%0d: got last=%b data=%h expected last=%b data=%h",
                             c, m_tx_tlast[t_ep[c]], m_tx_tdata[t_ep[c]*DW +: DW], t_lst[c], d);
                end
            end
            step();
        end
        n_checks++;
        if (tx_drop_count !== 16'd0) begin n_fail++; $display("FAIL route_drop_count: got %h expected 0000", tx_drop_count); end
    endtask

    task automatic test_tx_drop();
        bit [1:0] t_dst[5] = '{3, 0, 0, 1, 2};
        bit       t_lst[5] = '{0, 0, 0, 0, 1};
        m_tx_tready = '1;
        for (int c = 0; c < 5; c++) begin
            s_tx_tvalid = 1'b1; s_tx_tdest = t_dst[c]; s_tx_tlast = t_lst[c];
            s_tx_tdata = 64'hD0D0_0000_0000_0000 | 64'(c);
            #1;
            n_checks++;
            if ({s_tx_tready, m_tx_tvalid} !== 4'b1000) begin
                n_fail++; $display("FAIL drop_beat cyc%0d: got rdy=%b vld=%b expected rdy=1 vld=000", c, s_tx_tready, m_tx_tvalid);
            end
            if (c == 1) begin
                n_checks++;
                if (tx_drop_count !== 16'd1) begin n_fail++; $display("FAIL drop_count_first: got %h expected 0001", tx_drop_count); end
            end
            step();
        end
        n_checks++;
        if (tx_drop_count !== 16'd1) begin n_fail++; $display("FAIL drop_count_once: got %h expected 0001", tx_drop_count); end
        s_tx_tvalid = 1'b1; s_tx_tdest = 2'd3; s_tx_tlast = 1'b1;
        #1;
        n_checks++;
        if ({s_tx_tready, m_tx_tvalid} !== 4'b1000) begin
            n_fail++; $display("FAIL drop_single: got rdy=%b vld=%b expected rdy=1 vld=000", s_tx_tready, m_tx_tvalid);
        end
        repeat (65533) @(posedge clock);
        #1;
        n_checks++;
        if (tx_drop_count !== 16'hFFFE) begin n_fail++; $display("FAIL drop_count_fffe: got %h expected fffe", tx_drop_count); end
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (tx_drop_count !== 16'hFFFF) begin n_fail++; $display("FAIL drop_count_sat: got %h expected ffff", tx_drop_count); end
        s_tx_tvalid = 1'b0; s_tx_tlast = 1'b0;
        step();
    endtask

    task automatic test_reset_midpacket();
        set_rx(1, 1'b1, 64'h2222_0000_0000_0001, 1'b0, 1'b0);
        m_rx_tready = 1'b1;
        s_tx_tvalid = 1'b1; s_tx_tdest = 2'd2; s_tx_tlast = 1'b0; m_tx_tready = '1;
        s_tx_tdata = 64'hE0E0_0000_0000_0001;
        #1;
        n_checks++;
        if (m_tx_tvalid !== 3'b100) begin n_fail++; $display("FAIL mid_tx_first: got %b expected 100", m_tx_tvalid); end
        step();
        n_checks++;
        if ({m_rx_tvalid, m_rx_tdest, m_tx_tvalid} !== 6'b1_01_100) begin
            n_fail++; $display("FAIL mid_active: got rxv=%b dest=%0d txv=%b expected rxv=1 dest=1 txv=100", m_rx_tvalid, m_rx_tdest, m_tx_tvalid);
        end
        resetn = 1'b0;
        #1;
        n_checks++;
        if ({s_rx_tready, m_rx_tvalid, s_tx_tready, m_tx_tvalid} !== 8'h00) begin
            n_fail++; $display("FAIL mid_reset_outputs: got rxr=%b rxv=%b txr=%b txv=%b expected all 0", s_rx_tready, m_rx_tvalid, s_tx_tready, m_tx_tvalid);
        end
        n_checks++;
        if (tx_drop_count !== 16'd0) begin n_fail++; $display("FAIL mid_reset_count: got %h expected 0000", tx_drop_count); end
        set_rx(0, 1'b1, 64'h3333_0000_0000_0000, 1'b1, 1'b0);
        set_rx(1, 1'b1, 64'h3333_0000_0000_0001, 1'b1, 1'b0);
        s_tx_tdest = 2'd1; s_tx_tlast = 1'b1; s_tx_tdata = 64'hE0E0_0000_0000_0009;
        step();
        resetn = 1'b1;
        #1;
        n_checks++;
        if ({m_tx_tvalid, s_tx_tready, m_rx_tvalid} !== 5'b010_1_0) begin
            n_fail++; $display("FAIL mid_after_reset: got txv=%b txr=%b rxv=%b expected txv=010 txr=1 rxv=0", m_tx_tvalid, s_tx_tready, m_rx_tvalid);
        end
        step();
        s_tx_tvalid = 1'b0;
        #1;
        n_checks++;
        if ({m_rx_tvalid, m_rx_tdest, s_rx_tready} !== 6'b1_00_001) begin
            n_fail++; $display("FAIL mid_rx_regrant: got rxv=%b dest=%0d rdy=%b expected rxv=1 dest=0 rdy=001", m_rx_tvalid, m_rx_tdest, s_rx_tready);
        end
        n_checks++;
        if (m_tx_tvalid !== 3'b000) begin n_fail++; $display("FAIL mid_tx_idle: got %b expected 000", m_tx_tvalid); end
        step();
        for (int q = 0; q < NP; q++) set_rx(q, 1'b0, '0, 1'b0, 1'b0);
        step();
    endtask

    initial begin
        test_reset();
        test_rx_fairness();
        test_rx_backpressure();
        test_tx_routing();
        test_tx_drop();
        test_reset_midpacket();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
